// File: rtl/multi_edge_counter_pkg.sv
// Shared types for the multi-channel edge event counter.
// Edge-mode encoding plus the helper that picks which edge counts.
package multi_edge_counter_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  function automatic logic sel_edge(input edge_mode_t mode, input logic rise, input logic fall);
    logic inc;
    inc = 1'b0;
    case (mode)
      EDGE_RISE: inc = rise;
      EDGE_FALL: inc = fall;
      EDGE_BOTH: inc = rise | fall;
      default:   inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/edge_sync_detect.sv
// Synchroniser chain followed by a history flop; flags rising and falling edges
// of the synchronised input. The history flop tracks regardless of edge mode.
module edge_sync_detect
  import multi_edge_counter_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign fall = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/multi_edge_counter.sv
// N-channel synchronised edge event counter with sticky overflow, per-channel
// and global clear, and an atomic snapshot of all channel counts.
module multi_edge_counter
  import multi_edge_counter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int SATURATE    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_CH-1:0]         signal_in,
  input  logic [2*N_CH-1:0]       edge_mode,
  input  logic                    nul,
  input  logic [N_CH-1:0]         clr,
  input  logic                    snap,
  output logic [N_CH*CNT_W-1:0]   counter_out,
  output logic [N_CH*CNT_W-1:0]   snap_out,
  output logic                    snap_valid,
  output logic [N_CH-1:0]         ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [N_CH-1:0]  rise;
  logic [N_CH-1:0]  fall;
  logic [N_CH-1:0]  inc;
  logic [CNT_W-1:0] cnt_q  [N_CH];
  logic [CNT_W-1:0] snap_q [N_CH];
  logic [N_CH-1:0]  ovf_q;
  logic             snap_valid_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_sync_detect #(.SYNC_STAGES(SYNC_STAGES)) u_detect (
      .clk   (clk),
      .reset (reset),
      .d     (signal_in[g]),
      .rise  (rise[g]),
      .fall  (fall[g])
    );

    assign inc[g] = sel_edge(edge_mode_t'(edge_mode[2*g +: 2]), rise[g], fall[g]);
    assign counter_out[g*CNT_W +: CNT_W] = cnt_q[g];
    assign snap_out[g*CNT_W +: CNT_W]    = snap_q[g];
  end

  // Snapshot samples the pre-update count, so snap with clr/nul is an atomic read-and-clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ovf_q        <= '0;
      snap_valid_q <= 1'b0;
    end else begin
      snap_valid_q <= snap;
      for (int i = 0; i < N_CH; i++) begin
        if (snap) snap_q[i] <= cnt_q[i];
        if (nul || clr[i]) begin
          cnt_q[i] <= '0;
          ovf_q[i] <= 1'b0;
        end else if (inc[i]) begin
          if (cnt_q[i] == CNT_MAX) begin
            ovf_q[i] <= 1'b1;
            cnt_q[i] <= (SATURATE != 0) ? CNT_MAX : '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + CNT_ONE;
          end
        end
      end
    end
  end

  assign ovf        = ovf_q;
  assign snap_valid = snap_valid_q;

endmodule
